regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of entries in the multi-cycle write buffer (power of 2, 2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive cycles the buffer head may lose arbitration before a writeback stall is forced.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst, with all state sampled on the posedge of clk.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_we  in  1  pipeline writeback write request; it has no backpressure
- wb_addr  in  5  writeback destination register
- wb_data  in  32  writeback data
- md_valid  in  1  multi-cycle unit (mult/div) result valid
- md_addr  in  5  multi-cycle destination register
- md_data  in  32  multi-cycle result data
- md_ready  out  1  buffer can accept a result
- rf_regWr  out  1  register file write enable
- rf_writeimport  out  5  register file write address
- rf_Writedata  out  32  register file write data
- stall_wb  out  1  pipeline SHALL hold wb_we=0 in this cycle
- pend_mask  out  32  bit n=1 means a buffered write to register n is pending
- fifo_count  out  4  number of occupied buffer entries

Function
REQ-005 SHALL issue at most one register file write per cycle; the rf_* outputs SHALL be registered, giving 1-cycle latency from request to rf_regWr.
REQ-006 Priority at each posedge SHALL be: (a) wb_we with wb_addr!=0; (b) the buffer head; (c) a direct bypass of md_valid when the buffer is empty.
REQ-007 md_ready SHALL be 1 exactly when fifo_count<DEPTH; it SHALL be combinational from registered state and independent of md_valid.
REQ-008 A handshake (md_valid&&md_ready) SHALL enqueue the result unless it was taken by bypass that same cycle.
REQ-009 A handshake with md_addr==0 SHALL be accepted and dropped: no enqueue, no write.
REQ-010 wb_we with wb_addr==0 SHALL produce no write and SHALL NOT block the buffer.
REQ-011 The buffer SHALL be FIFO-ordered; simultaneous push and pop SHALL keep fifo_count unchanged; a push when full SHALL be impossible by REQ-007, with no pass-through.
REQ-012 The starvation counter SHALL increment each cycle the buffer is non-empty and its head is not issued, and SHALL clear on a head issue or when the buffer is empty.
REQ-013 When the starvation counter reaches STARVE_LIMIT, stall_wb SHALL be registered high for exactly one cycle, and in that cycle the head SHALL issue; wb_we=1 during stall_wb is a protocol error and is flagged by assertion.
REQ-014 pend_mask SHALL be the OR of one-hot(addr) over the valid buffer entries; a bit SHALL clear only when no remaining entry targets that register.
REQ-015 The hazard unit uses pend_mask to stall readers and writers of pending registers; no write reordering is permitted for the same address.
REQ-016 When no write is issued, rf_regWr SHALL be 0, and rf_writeimport/rf_Writedata SHALL hold their previous values.

Reset
REQ-017 rst SHALL clear rf_regWr, rf_writeimport, rf_Writedata, stall_wb, fifo_count, pend_mask, the starvation counter and the FIFO pointers to 0; md_ready=1 after reset.
REQ-018 rst asserted mid-operation SHALL discard all buffered writes and any in-flight write without issuing them; rst takes priority over all requests.

Structure
REQ-019 The register address width (5), data width (32) and register count (32) SHALL live in the shared CPU package; DEPTH and STARVE_LIMIT remain module parameters.
REQ-020 The buffer SHALL be a sub-module, wr_fifo (parameterised DEPTH, exposing count and per-entry valid/addr for pend_mask); arbitration and starvation logic stay in the top.

Verification
REQ-021 Scenario: reset, then md_valid addr=3 data=0xDEADBEEF with no WB -> next cycle rf_regWr=1, rf_writeimport=3, data=0xDEADBEEF, fifo_count stays 0.
REQ-022 Scenario: wb_we addr=5 data=0x11 and md addr=6 data=0x22 in the same cycle -> cycle+1 writes r5; cycle+2 writes r6; pend_mask[6]=1 only during cycle+1.
REQ-023 Scenario: wb_we every cycle, 5 md results with DEPTH=4 -> md_ready=0 after the 4th enqueue; stall_wb pulses 4 cycles after the first enqueue and the head issues then.
REQ-024 Scenario: md addr=0 and wb addr=0 -> no rf_regWr, fifo_count=0, pend_mask=0.
REQ-025 Scenario: two buffered entries both to r9, then one pops -> pend_mask[9] stays 1 until the second entry issues.
REQ-026 Scenario: rst for one cycle with 3 entries buffered -> fifo_count=0, pend_mask=0, no write of the buffered data afterwards.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter_pkg
//  Description : Shared CPU register-file constants, arbitration grant
//                encoding and a one-hot helper for the write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_arbiter_pkg;

    // Register file geometry shared across the CPU
    localparam int c_REG_ADDR_W = 5;
    localparam int c_REG_DATA_W = 32;
    localparam int c_NUM_REGS   = 32;

    // Occupancy counter width; covers buffer depths up to 8 entries
    localparam int c_CNT_W      = 4;

    // Which requester owns the single register-file write port this cycle
    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_WB     = 2'd1,
        GRANT_HEAD   = 2'd2,
        GRANT_BYPASS = 2'd3
    } grant_e;

    // One-hot decode of a register address into a register-file-wide mask
    function automatic logic [c_NUM_REGS-1:0] reg_onehot(input logic [c_REG_ADDR_W-1:0] addr);
        logic [c_NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wr_fifo
//  Description : In-order buffer of pending multi-cycle register writes.
//                Exposes occupancy plus per-entry valid/address so the
//                parent can build the pending-register mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [c_REG_ADDR_W-1:0]       i_push_addr,
    input  logic [c_REG_DATA_W-1:0]       i_push_data,
    input  logic                          i_pop,
    output logic [c_REG_ADDR_W-1:0]       o_head_addr,
    output logic [c_REG_DATA_W-1:0]       o_head_data,
    output logic                          o_empty,
    output logic [c_CNT_W-1:0]            o_count,
    output logic [DEPTH-1:0]              o_entry_valid,
    output logic [DEPTH*c_REG_ADDR_W-1:0] o_entry_addr
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_REG_ADDR_W-1:0] r_addr [DEPTH];
    logic [c_REG_DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic                    w_push;
    logic                    w_pop;
    logic [DEPTH-1:0]        w_valid_nxt;
    logic [c_CNT_W-1:0]      w_count_nxt;

    // A full buffer refuses pushes outright; there is no pass-through path
    assign w_push = i_push && (r_count != c_FULL_CNT);
    assign w_pop  = i_pop  && (r_count != '0);

    // Per-slot valid bits follow the pointers so pend_mask tracks live entries only
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_pop) begin
            w_valid_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_valid_nxt[r_wr_ptr] = 1'b1;
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // Entry payload storage; r_valid qualifies every use so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and valid bits; reset discards every buffered write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign o_head_addr   = r_addr[r_rd_ptr];
    assign o_head_data   = r_data[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_count       = r_count;
    assign o_entry_valid = r_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign o_entry_addr[gi*c_REG_ADDR_W +: c_REG_ADDR_W] = r_addr[gi];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Arbitrates the single register-file write port between the
//                pipeline writeback and a buffered multi-cycle (mult/div)
//                result stream, with starvation-driven writeback stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_we,
    input  logic [c_REG_ADDR_W-1:0] wb_addr,
    input  logic [c_REG_DATA_W-1:0] wb_data,
    input  logic                    md_valid,
    input  logic [c_REG_ADDR_W-1:0] md_addr,
    input  logic [c_REG_DATA_W-1:0] md_data,
    output logic                    md_ready,
    output logic                    rf_regWr,
    output logic [c_REG_ADDR_W-1:0] rf_writeimport,
    output logic [c_REG_DATA_W-1:0] rf_Writedata,
    output logic                    stall_wb,
    output logic [c_NUM_REGS-1:0]   pend_mask,
    output logic [c_CNT_W-1:0]      fifo_count
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);
    localparam logic [c_CNT_W-1:0]    c_FULL_CNT   = c_CNT_W'(DEPTH);

    // Registered state
    logic                    r_rf_regwr;
    logic [c_REG_ADDR_W-1:0] r_rf_addr;
    logic [c_REG_DATA_W-1:0] r_rf_data;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic                    r_stall_wb;

    // Buffer view
    logic [c_REG_ADDR_W-1:0]       w_head_addr;
    logic [c_REG_DATA_W-1:0]       w_head_data;
    logic                          w_empty;
    logic [c_CNT_W-1:0]            w_count;
    logic [DEPTH-1:0]              w_entry_valid;
    logic [DEPTH*c_REG_ADDR_W-1:0] w_entry_addr;

    // Arbitration
    logic                  w_wb_req;
    logic                  w_md_hs;
    logic                  w_md_live;
    grant_e                w_grant;
    logic                  w_head_issue;
    logic                  w_push;
    logic [c_STARVE_W-1:0] w_starve_nxt;
    logic [c_NUM_REGS-1:0] w_pend_mask;

    // r0 writes are architecturally void, so they neither write nor compete
    assign w_wb_req     = wb_we && (wb_addr != '0);
    assign md_ready     = (w_count < c_FULL_CNT);
    assign w_md_hs      = md_valid && md_ready;
    assign w_md_live    = w_md_hs && (md_addr != '0);
    assign w_head_issue = (w_grant == GRANT_HEAD);
    // A live result is buffered unless it went straight to the register file
    assign w_push       = w_md_live && (w_grant != GRANT_BYPASS);

    // Write-port grant: a pending starvation stall forces the head, otherwise
    // writeback, then the head, then a bypass into an empty buffer
    always_comb begin
        w_grant = GRANT_NONE;
        if (!w_empty && r_stall_wb) begin
            w_grant = GRANT_HEAD;
        end else if (w_wb_req) begin
            w_grant = GRANT_WB;
        end else if (!w_empty) begin
            w_grant = GRANT_HEAD;
        end else if (w_md_live) begin
            w_grant = GRANT_BYPASS;
        end
    end

    // Starvation count of consecutive cycles the head was passed over
    always_comb begin
        w_starve_nxt = '0;
        if (!w_empty && !w_head_issue) begin
            w_starve_nxt = r_starve_cnt + c_STARVE_ONE;
        end
    end

    // Pending-register mask is the union of every live buffered destination
    always_comb begin
        w_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_pend_mask = w_pend_mask | reg_onehot(w_entry_addr[i*c_REG_ADDR_W +: c_REG_ADDR_W]);
            end
        end
    end

    // Register-file write port; address and data hold when nothing issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_regwr <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
        end else begin
            r_rf_regwr <= 1'b0;
            case (w_grant)
                GRANT_WB: begin
                    r_rf_regwr <= 1'b1;
                    r_rf_addr  <= wb_addr;
                    r_rf_data  <= wb_data;
                end
                GRANT_HEAD: begin
                    r_rf_regwr <= 1'b1;
                    r_rf_addr  <= w_head_addr;
                    r_rf_data  <= w_head_data;
                end
                GRANT_BYPASS: begin
                    r_rf_regwr <= 1'b1;
                    r_rf_addr  <= md_addr;
                    r_rf_data  <= md_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Starvation counter and the one-cycle writeback stall it raises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_stall_wb   <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_stall_wb   <= (w_starve_nxt == c_STARVE_MAX);
        end
    end

    wr_fifo #(
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_addr   (md_addr),
        .i_push_data   (md_data),
        .i_pop         (w_head_issue),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_empty       (w_empty),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    assign rf_regWr       = r_rf_regwr;
    assign rf_writeimport = r_rf_addr;
    assign rf_Writedata   = r_rf_data;
    assign stall_wb       = r_stall_wb;
    assign pend_mask      = w_pend_mask;
    assign fifo_count     = w_count;

    // The pipeline must hold writeback off while the forced head write drains
    a_no_wb_during_stall: assert property (@(posedge clk) disable iff (rst) !(stall_wb && wb_we))
        else $error("wb_we asserted while stall_wb is high");

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Self-checking bench for regfile_wr_arbiter; directed
//                scenarios followed by random traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_regWr;
    logic [4:0]  rf_writeimport;
    logic [31:0] rf_Writedata;
    logic        stall_wb;
    logic [31:0] pend_mask;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    // Reference model: the buffer as a plain queue of (addr, data)
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          m_starve;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .md_valid       (md_valid),
        .md_addr        (md_addr),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .rf_regWr       (rf_regWr),
        .rf_writeimport (rf_writeimport),
        .rf_Writedata   (rf_Writedata),
        .stall_wb       (stall_wb),
        .pend_mask      (pend_mask),
        .fifo_count     (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // One clock edge of the architectural rules applied to the driven inputs
    task automatic model_edge();
        int n;
        bit wb_req;
        bit hs;
        bit head;
        bit byp;
        n      = q.size();
        wb_req = wb_we && (wb_addr != 0);
        hs     = md_valid && (n < DEPTH);
        head   = (n > 0) && (m_stall || !wb_req);
        byp    = (n == 0) && !wb_req && hs && (md_addr != 0);
        m_we   = 1'b0;
        if (head) begin
            m_we   = 1'b1;
            m_addr = q[0].addr;
            m_data = q[0].data;
            q.delete(0);
        end else if (wb_req) begin
            m_we   = 1'b1;
            m_addr = wb_addr;
            m_data = wb_data;
        end else if (byp) begin
            m_we   = 1'b1;
            m_addr = md_addr;
            m_data = md_data;
        end
        if (hs && (md_addr != 0) && !byp) begin
            q.push_back('{addr: md_addr, data: md_data});
        end
        if (n == 0 || head) m_starve = 0;
        else                m_starve++;
        m_stall = (m_starve == STARVE_LIMIT);
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] pm;
        pm = '0;
        foreach (q[i]) pm[q[i].addr] = 1'b1;
        check({tag, ".regWr"},   {31'd0, rf_regWr},   {31'd0, m_we});
        check({tag, ".addr"},    {27'd0, rf_writeimport}, {27'd0, m_addr});
        check({tag, ".data"},    rf_Writedata,        m_data);
        check({tag, ".stall"},   {31'd0, stall_wb},   {31'd0, m_stall});
        check({tag, ".count"},   {28'd0, fifo_count}, q.size());
        check({tag, ".pend"},    pend_mask,           pm);
        check({tag, ".ready"},   {31'd0, md_ready},   {31'd0, (q.size() < DEPTH)});
    endtask

    // Drive one cycle of stimulus; writeback is held off during a stall
    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input string tag);
        wb_we    = we && !m_stall && !stall_wb;
        wb_addr  = wa;
        wb_data  = wd;
        md_valid = mv;
        md_addr  = ma;
        md_data  = md;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        wb_we    = 1'b1;
        wb_addr  = 5'd17;
        wb_data  = 32'hCAFE_0001;
        md_valid = 1'b1;
        md_addr  = 5'd18;
        md_data  = 32'hCAFE_0002;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs(tag);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int k;
        int first_stall;
        bit acc;
        bit we;
        bit mv;
        logic [4:0] wa;
        logic [4:0] ma;

        model_reset();
        rst = 1'b1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        do_reset("rst0");
        do_reset("rst1");
        check("rst.regWr_const", {31'd0, rf_regWr}, 32'd0);
        check("rst.ready_const", {31'd0, md_ready}, 32'd1);

        // Bypass into empty buffer
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, "s021");
        check("s021.addr_const", {27'd0, rf_writeimport}, 32'd3);
        check("s021.data_const", rf_Writedata, 32'hDEADBEEF);
        check("s021.count_const", {28'd0, fifo_count}, 32'd0);
        idle("s021.idle");
        check("s021.hold_addr", {27'd0, rf_writeimport}, 32'd3);

        // Writeback wins, result is buffered for one cycle
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, "s022.c1");
        check("s022.c1_addr", {27'd0, rf_writeimport}, 32'd5);
        check("s022.c1_pend6", {31'd0, pend_mask[6]}, 32'd1);
        idle("s022.c2");
        check("s022.c2_addr", {27'd0, rf_writeimport}, 32'd6);
        check("s022.c2_data", rf_Writedata, 32'h22);
        check("s022.c2_pend6", {31'd0, pend_mask[6]}, 32'd0);
        drain("s022.drain");

        // Continuous writeback starves the buffer until a forced stall
        k = 0;
        first_stall = -1;
        for (int i = 0; i < 12; i++) begin
            acc = (k < 5) && (q.size() < DEPTH);
            step(1'b1, 5'd1, 32'h100 + i, (k < 5), 5'(10 + k), 32'hA000 + k, "s023");
            if (acc) k++;
            if (i == 3) check("s023.ready_full", {31'd0, md_ready}, 32'd0);
            if (stall_wb && first_stall < 0) first_stall = i;
            if (i == 5) check("s023.head_addr", {27'd0, rf_writeimport}, 32'd10);
        end
        check("s023.stall_at", first_stall, 32'd4);
        drain("s023.drain");

        // r0 on both sources: nothing written, nothing buffered
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, "s024");
        check("s024.regWr_const", {31'd0, rf_regWr}, 32'd0);
        check("s024.pend_const", pend_mask, 32'd0);
        // writeback to r0 does not block a waiting head
        step(1'b1, 5'd1, 32'h77, 1'b1, 5'd7, 32'h88, "s024.b1");
        step(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0, "s024.b2");
        check("s024.head_addr", {27'd0, rf_writeimport}, 32'd7);
        drain("s024.drain");

        // Two buffered writes to r9 keep pend_mask[9] set until both drain
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9A, "s025.p1");
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9B, "s025.p2");
        idle("s025.pop1");
        check("s025.pend9_held", {31'd0, pend_mask[9]}, 32'd1);
        idle("s025.pop2");
        check("s025.pend9_clr", {31'd0, pend_mask[9]}, 32'd0);
        check("s025.last_data", rf_Writedata, 32'h9B);
        drain("s025.drain");

        // Reset with three entries buffered discards them
        for (int i = 0; i < 3; i++) step(1'b1, 5'd4, 32'h40 + i, 1'b1, 5'(20 + i), 32'hB0 + i, "s026.fill");
        check("s026.count3", {28'd0, fifo_count}, 32'd3);
        do_reset("s026.rst");
        check("s026.pend_const", pend_mask, 32'd0);
        for (int i = 0; i < 4; i++) idle("s026.after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd.rst");
            end else begin
                we = ($urandom_range(0, 9) < 6);
                mv = ($urandom_range(0, 9) < 5);
                wa = 5'($urandom_range(0, 7));
                ma = 5'($urandom_range(0, 7));
                step(we, wa, $urandom, mv, ma, $urandom, "rnd");
            end
        end
        drain("final.drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
